// File: rtl/draw_engine_arbiter.sv
// Round-robin owner of the shared draw-object engine.
// Latches the winning command and routes engine completion back to it.
module draw_engine_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [9*NUM_REQ-1:0]   req_x,
  input  logic [8*NUM_REQ-1:0]   req_y,
  input  logic [5*NUM_REQ-1:0]   req_type,
  input  logic                   eng_done,
  output logic                   eng_start,
  output logic [8:0]             eng_x,
  output logic [7:0]             eng_y,
  output logic [4:0]             eng_type,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] grant_q;
  logic [8:0]         x_q;
  logic [7:0]         y_q;
  logic [4:0]         type_q;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic [1:0] gidx;

  // First pending requester at or above ptr, wrapping mod 4
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = 2'd0;
    unique case (1'b1)
      grant_q[1]: gidx = 2'd1;
      grant_q[2]: gidx = 2'd2;
      grant_q[3]: gidx = 2'd3;
      default:    gidx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      ptr     <= 2'd0;
      grant_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      type_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            grant_q <= NUM_REQ'(1) << win;
            x_q     <= req_x[9*int'(win) +: 9];
            y_q     <= req_y[8*int'(win) +: 8];
            type_q  <= req_type[5*int'(win) +: 5];
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (eng_done) state <= S_RELEASE;
        end
        S_RELEASE: begin
          ptr     <= gidx + 2'd1;
          grant_q <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign eng_start = (state == S_BUSY);
  assign busy      = (state == S_BUSY) || (state == S_RELEASE);
  assign grant     = grant_q;
  assign eng_x     = eng_start ? x_q : '0;
  assign eng_y     = eng_start ? y_q : '0;
  assign eng_type  = eng_start ? type_q : '0;
  assign done      = eng_start ? (grant_q & {NUM_REQ{eng_done}}) : '0;

endmodule
